// File: rtl/vector_register_file.sv
// ============================================================================
// Module  : vector_register_file
// Brief   : Multi-lane register file with per-lane masked writes, write-first
//           bypass on registered read ports, and a one-register-per-cycle wipe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vector_register_file #(
  parameter int DATA_W   = 32,
  parameter int LANES    = 4,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    regWrite,
  input  logic [ADDR_W-1:0]       A1,
  input  logic [ADDR_W-1:0]       A2,
  input  logic [ADDR_W-1:0]       A3,
  input  logic [LANES*DATA_W-1:0] WD3,
  input  logic [LANES-1:0]        WE_lane,
  input  logic                    wipe_req,
  output logic [LANES*DATA_W-1:0] RD1,
  output logic [LANES*DATA_W-1:0] RD2,
  output logic                    wipe_busy,
  output logic                    wipe_done
);

  localparam logic [ADDR_W-1:0] c_last_reg = ADDR_W'(NUM_REGS - 1);

  // Bit 0 is busy, bit 1 is done, so both outputs come straight from flops.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WIPE = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [ADDR_W-1:0]         r_wipe_cnt;
  logic [DATA_W-1:0]         r_mem [NUM_REGS][LANES];
  logic [LANES*DATA_W-1:0]   w_rd1_next;
  logic [LANES*DATA_W-1:0]   w_rd2_next;
  logic                      w_wiping;
  logic                      w_wr_ok;
  logic                      w_a1_ok;
  logic                      w_a2_ok;
  logic                      w_a1_wiped;
  logic                      w_a2_wiped;

  assign w_wiping   = (r_state == ST_WIPE);
  assign w_wr_ok    = regWrite && !w_wiping && (32'(A3) < NUM_REGS);
  assign w_a1_ok    = (32'(A1) < NUM_REGS);
  assign w_a2_ok    = (32'(A2) < NUM_REGS);
  assign w_a1_wiped = w_wiping && (r_wipe_cnt == A1);
  assign w_a2_wiped = w_wiping && (r_wipe_cnt == A2);

  // ---------------------------------------------------------------- wipe FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (wipe_req) w_state_next = ST_WIPE;
      ST_WIPE: if (r_wipe_cnt == c_last_reg) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wipe_cnt <= '0;
    end else if (r_state == ST_IDLE && wipe_req) begin
      r_wipe_cnt <= '0;
    end else if (w_wiping && r_wipe_cnt != c_last_reg) begin
      r_wipe_cnt <= r_wipe_cnt + ADDR_W'(1);
    end
  end

  assign wipe_busy = r_state[0];
  assign wipe_done = r_state[1];

  // ------------------------------------------------------------ storage
  // Wipe takes priority; it only ever coincides with a dropped write anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int k = 0; k < LANES; k++) begin
          r_mem[i][k] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int k = 0; k < LANES; k++) begin
          if (w_wiping && r_wipe_cnt == ADDR_W'(i)) begin
            r_mem[i][k] <= '0;
          end else if (w_wr_ok && A3 == ADDR_W'(i) && WE_lane[k]) begin
            r_mem[i][k] <= WD3[k*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // ------------------------------------------------------------ read ports
  for (genvar k = 0; k < LANES; k++) begin : g_rd_lane
    assign w_rd1_next[k*DATA_W +: DATA_W] =
        (!w_a1_ok || w_a1_wiped)            ? '0 :
        (w_wr_ok && A3 == A1 && WE_lane[k]) ? WD3[k*DATA_W +: DATA_W] :
                                              r_mem[A1][k];
    assign w_rd2_next[k*DATA_W +: DATA_W] =
        (!w_a2_ok || w_a2_wiped)            ? '0 :
        (w_wr_ok && A3 == A2 && WE_lane[k]) ? WD3[k*DATA_W +: DATA_W] :
                                              r_mem[A2][k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RD1 <= '0;
      RD2 <= '0;
    end else begin
      RD1 <= w_rd1_next;
      RD2 <= w_rd2_next;
    end
  end

endmodule

`default_nettype wire
